// File: rtl/dino_frame_writer_if.sv
// Avalon-MM write bus between the frame writer (master) and the display register slave.
interface dino_frame_writer_if;
    logic        av_waitrequest;
    logic        av_chipselect;
    logic        av_write;
    logic [8:0]  av_address;
    logic [31:0] av_writedata;

    modport master (
        input  av_waitrequest,
        output av_chipselect,
        output av_write,
        output av_address,
        output av_writedata
    );

    modport slave (
        output av_waitrequest,
        input  av_chipselect,
        input  av_write,
        input  av_address,
        input  av_writedata
    );
endinterface

// File: rtl/dino_frame_writer.sv
// Per-frame dino game engine: steps game state on each vsync fall, then
// bursts the 13 sprite/score registers to the display over Avalon-MM.
module dino_frame_writer #(
    parameter logic [7:0] DINO_X    = 8'd40,
    parameter logic [7:0] GROUND_Y  = 8'd200,
    parameter logic [4:0] JUMP_V    = 5'd12,
    parameter logic [7:0] CAC_START = 8'd250,
    parameter logic [3:0] SCROLL    = 4'd4,
    parameter logic [7:0] PARK_X    = 8'd0,
    parameter logic [7:0] PARK_Y    = 8'd0,
    parameter logic [7:0] SCORE_X   = 8'd225,
    parameter logic [7:0] SCORE_Y   = 8'd185
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vsync_n,
    input  logic                       jump_btn,
    input  logic                       duck_btn,
    dino_frame_writer_if.master        av,
    output logic                       game_over,
    output logic                       overrun
);

    localparam int unsigned  NREGS    = 13;
    localparam logic [8:0]   DINO_END = {1'b0, DINO_X} + 9'd24;
    localparam logic [7:0]   HIT_Y    = GROUND_Y - 8'd24;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WRITE} state_t;

    state_t      state;
    logic        vs_q;
    logic        pend;
    logic        jump_req;
    logic [3:0]  idx;
    logic [7:0]  snap [NREGS];

    logic [7:0]  y;
    logic        air;
    logic [5:0]  vel;
    logic [7:0]  cac_x;
    logic [3:0]  score;

    logic        vs_edge;
    logic [7:0]  y_n;
    logic        air_n;
    logic [5:0]  vel_n;
    logic [7:0]  cac_n;
    logic [3:0]  score_n;
    logic        go_n;
    logic [8:0]  y_step;
    logic        pose_jump;
    logic        pose_duck;
    logic        pose_dino;
    logic [7:0]  wr_val [NREGS];
    logic [3:0]  idx_nxt;

    assign vs_edge = vs_q & ~vsync_n;
    assign idx_nxt = idx + 4'd1;

    // Next game state for this frame; collision is judged on the updated positions.
    always_comb begin
        y_n     = y;
        air_n   = air;
        vel_n   = vel;
        cac_n   = cac_x;
        score_n = score;
        go_n    = game_over;
        y_step  = '0;
        if (game_over) begin
            if (jump_req) begin
                y_n     = GROUND_Y;
                air_n   = 1'b0;
                vel_n   = '0;
                cac_n   = CAC_START;
                score_n = '0;
                go_n    = 1'b0;
            end
        end else begin
            if (!air && jump_req) begin
                air_n = 1'b1;
                vel_n = {1'b0, JUMP_V};
            end
            if (air_n) begin
                y_step = {1'b0, y} - {{3{vel_n[5]}}, vel_n};
                vel_n  = vel_n - 6'd1;
                if ($signed(y_step) >= $signed({1'b0, GROUND_Y})) begin
                    y_n   = GROUND_Y;
                    air_n = 1'b0;
                    vel_n = '0;
                end else begin
                    y_n = y_step[7:0];
                end
            end
            if (cac_x < {4'b0, SCROLL}) begin
                cac_n   = CAC_START;
                score_n = (score == 4'd9) ? '0 : score + 4'd1;
            end else begin
                cac_n = cac_x - {4'b0, SCROLL};
            end
            if (cac_n >= DINO_X && {1'b0, cac_n} < DINO_END && y_n > HIT_Y)
                go_n = 1'b1;
        end
    end

    always_comb begin
        pose_jump  = air_n;
        pose_duck  = !air_n && duck_btn;
        pose_dino  = !pose_jump && !pose_duck;
        wr_val[0]  = pose_dino ? DINO_X : PARK_X;
        wr_val[1]  = pose_dino ? y_n    : PARK_Y;
        wr_val[2]  = pose_jump ? DINO_X : PARK_X;
        wr_val[3]  = pose_jump ? y_n    : PARK_Y;
        wr_val[4]  = pose_duck ? DINO_X : PARK_X;
        wr_val[5]  = pose_duck ? y_n    : PARK_Y;
        wr_val[6]  = cac_n;
        wr_val[7]  = GROUND_Y;
        wr_val[8]  = PARK_X;
        wr_val[9]  = PARK_Y;
        wr_val[10] = {4'b0, score_n};
        wr_val[11] = SCORE_X;
        wr_val[12] = SCORE_Y;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            vs_q            <= 1'b1;
            pend            <= 1'b0;
            overrun         <= 1'b0;
            jump_req        <= 1'b0;
            game_over       <= 1'b0;
            idx             <= '0;
            y               <= GROUND_Y;
            air             <= 1'b0;
            vel             <= '0;
            cac_x           <= CAC_START;
            score           <= '0;
            av.av_write     <= 1'b0;
            av.av_chipselect<= 1'b0;
            av.av_address   <= '0;
            av.av_writedata <= '0;
            for (int unsigned i = 0; i < NREGS; i++)
                snap[i] <= '0;
        end else begin
            vs_q <= vsync_n;
            if (vs_edge && pend)
                overrun <= 1'b1;

            // A press landing in the UPDATE cycle survives to the next frame.
            if (state == S_UPDATE)
                jump_req <= jump_btn;
            else if (jump_btn)
                jump_req <= 1'b1;

            // An edge arriving together with a pending one stays pending.
            if (state == S_IDLE) begin
                if (pend || vs_edge)
                    pend <= pend & vs_edge;
            end else if (vs_edge) begin
                pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pend || vs_edge)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    y                <= y_n;
                    air              <= air_n;
                    vel              <= vel_n;
                    cac_x            <= cac_n;
                    score            <= score_n;
                    game_over        <= go_n;
                    snap             <= wr_val;
                    idx              <= '0;
                    av.av_write      <= 1'b1;
                    av.av_chipselect <= 1'b1;
                    av.av_address    <= '0;
                    av.av_writedata  <= {24'b0, wr_val[0]};
                    state            <= S_WRITE;
                end
                S_WRITE: begin
                    if (!av.av_waitrequest) begin
                        if (idx == 4'(NREGS - 1)) begin
                            av.av_write      <= 1'b0;
                            av.av_chipselect <= 1'b0;
                            av.av_address    <= '0;
                            av.av_writedata  <= '0;
                            idx              <= '0;
                            state            <= S_IDLE;
                        end else begin
                            idx             <= idx_nxt;
                            av.av_address   <= {5'b0, idx_nxt};
                            av.av_writedata <= {24'b0, snap[idx_nxt]};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dino_frame_writer.sv
// Directed bench for dino_frame_writer: frame bursts, jump arc, cactus wrap,
// collision/restart, wait states, back-to-back frames and mid-burst reset.
module tb_dino_frame_writer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic vsync_n = 1'b1;
    logic jump_btn = 1'b0;
    logic duck_btn = 1'b0;
    logic game_over;
    logic overrun;

    dino_frame_writer_if bus ();

    dino_frame_writer #(
        .DINO_X(8'd40), .GROUND_Y(8'd200), .JUMP_V(5'd12), .CAC_START(8'd250),
        .SCROLL(4'd4), .PARK_X(8'd0), .PARK_Y(8'd0), .SCORE_X(8'd225), .SCORE_Y(8'd185)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vsync_n(vsync_n),
        .jump_btn(jump_btn),
        .duck_btn(duck_btn),
        .av(bus),
        .game_over(game_over),
        .overrun(overrun)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [7:0]  cap_data [32];
    logic [7:0]  exp13 [13];
    int          cap_total, cap_first, cap_last, high_cnt, a5_cycles, stalls_done;
    bit          order_ok, cs_ok, upper_ok, a5_chg, stall_en, extra_edges;
    logic [31:0] a5_data;

    // Expected register image for a given pose (0 dino, 1 jump, 2 duck).
    task automatic build_exp(input int pose, input logic [7:0] yv, input logic [7:0] cac,
                             input logic [3:0] sc);
        for (int k = 0; k < 13; k++) exp13[k] = 8'd0;
        exp13[2*pose]     = 8'd40;
        exp13[2*pose + 1] = yv;
        exp13[6]  = cac;
        exp13[7]  = 8'd200;
        exp13[10] = {4'b0, sc};
        exp13[11] = 8'd225;
        exp13[12] = 8'd185;
    endtask

    // One frame: drop vsync and watch a fixed window of cycles.
    task automatic run_frame(input bit jmp, input bit dk);
        cap_total = 0; cap_first = -1; cap_last = -1; high_cnt = 0;
        a5_cycles = 0; stalls_done = 0;
        order_ok = 1; cs_ok = 1; upper_ok = 1; a5_chg = 0; a5_data = '0;
        for (int k = 0; k < 32; k++) cap_data[k] = 8'hxx;
        if (jmp) begin
            jump_btn = 1'b1;
            @(negedge clk);
            jump_btn = 1'b0;
        end
        duck_btn = dk;
        vsync_n  = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i == 4) vsync_n = 1'b1;
            if (extra_edges) begin
                if (i == 6 || i == 9)  vsync_n = 1'b0;
                if (i == 7 || i == 10) vsync_n = 1'b1;
            end
            if (stall_en && bus.av_write === 1'b1 && bus.av_address == 9'd5 && stalls_done < 3) begin
                bus.av_waitrequest = 1'b1;
                stalls_done++;
            end else begin
                bus.av_waitrequest = 1'b0;
            end
            if (bus.av_chipselect !== bus.av_write) cs_ok = 0;
            if (bus.av_write === 1'b1) begin
                high_cnt++;
                if (cap_first < 0) cap_first = i;
                cap_last = i;
                if (bus.av_writedata[31:8] !== 24'd0) upper_ok = 0;
                if (bus.av_address == 9'd5) begin
                    if (a5_cycles == 0) a5_data = bus.av_writedata;
                    else if (bus.av_writedata !== a5_data) a5_chg = 1;
                    a5_cycles++;
                end
                if (!bus.av_waitrequest) begin
                    if (bus.av_address !== 9'(cap_total % 13)) order_ok = 0;
                    if (cap_total < 32) cap_data[cap_total] = bus.av_writedata[7:0];
                    cap_total++;
                end
            end
        end
        duck_btn = 1'b0;
        bus.av_waitrequest = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (bus.av_write !== 1'b0) begin failed++; $display("FAIL reset_write: got %b expected 0", bus.av_write); end
        tests++; if (bus.av_chipselect !== 1'b0) begin failed++; $display("FAIL reset_cs: got %b expected 0", bus.av_chipselect); end
        tests++; if (bus.av_address !== 9'd0) begin failed++; $display("FAIL reset_addr: got %0d expected 0", bus.av_address); end
        tests++; if (bus.av_writedata !== 32'd0) begin failed++; $display("FAIL reset_data: got %0h expected 0", bus.av_writedata); end
        tests++; if (game_over !== 1'b0) begin failed++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_frame;
        run_frame(0, 0);
        build_exp(0, 8'd200, 8'd246, 4'd0);
        tests++; if (cap_total != 13) begin failed++; $display("FAIL idle_count: got %0d expected 13", cap_total); end
        tests++; if (cap_first != 2) begin failed++; $display("FAIL idle_first: got %0d expected 2", cap_first); end
        tests++; if (cap_last != 14) begin failed++; $display("FAIL idle_last: got %0d expected 14", cap_last); end
        tests++; if (high_cnt != 13) begin failed++; $display("FAIL idle_high: got %0d expected 13", high_cnt); end
        tests++; if (!order_ok) begin failed++; $display("FAIL idle_order: got out-of-order addresses expected 0..12"); end
        tests++; if (!cs_ok) begin failed++; $display("FAIL idle_cs: got chipselect != write expected equal"); end
        tests++; if (!upper_ok) begin failed++; $display("FAIL idle_upper: got nonzero [31:8] expected 0"); end
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL idle_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
    endtask

    task automatic test_duck;
        run_frame(0, 1);
        build_exp(2, 8'd200, 8'd242, 4'd0);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL duck_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
    endtask

    task automatic test_jump;
        for (int f = 3; f <= 39; f++) run_frame(0, 0);
        run_frame(1, 0);
        build_exp(1, 8'd188, 8'd90, 4'd0);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL jump_start idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
        run_frame(0, 0);
        tests++; if (cap_data[3] !== 8'd177) begin failed++; $display("FAIL jump_y2: got %0d expected 177", cap_data[3]); end
        tests++; if (cap_data[1] !== 8'd0) begin failed++; $display("FAIL jump_dino_parked: got %0d expected 0", cap_data[1]); end
        run_frame(0, 0);
        tests++; if (cap_data[3] !== 8'd167) begin failed++; $display("FAIL jump_y3: got %0d expected 167", cap_data[3]); end
        run_frame(0, 1);
        build_exp(1, 8'd158, 8'd78, 4'd0);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL jump_over_duck idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
        for (int f = 44; f <= 61; f++) run_frame(0, 0);
    endtask

    task automatic test_cactus_wrap;
        run_frame(0, 0);
        tests++; if (cap_data[6] !== 8'd2) begin failed++; $display("FAIL wrap_pre_cac: got %0d expected 2", cap_data[6]); end
        tests++; if (game_over !== 1'b0) begin failed++; $display("FAIL wrap_no_hit: got %b expected 0", game_over); end
        run_frame(0, 0);
        tests++; if (cap_data[6] !== 8'd250) begin failed++; $display("FAIL wrap_cac: got %0d expected 250", cap_data[6]); end
        tests++; if (cap_data[10] !== 8'd1) begin failed++; $display("FAIL wrap_score: got %0d expected 1", cap_data[10]); end
        tests++; if (cap_data[3] !== 8'd188) begin failed++; $display("FAIL jump_descend: got %0d expected 188", cap_data[3]); end
        run_frame(0, 0);
        build_exp(0, 8'd200, 8'd246, 4'd1);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL land idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
    endtask

    task automatic test_collision;
        for (int f = 65; f <= 109; f++) run_frame(0, 0);
        tests++; if (game_over !== 1'b0) begin failed++; $display("FAIL pre_hit: got %b expected 0", game_over); end
        run_frame(0, 0);
        tests++; if (game_over !== 1'b1) begin failed++; $display("FAIL hit: got %b expected 1", game_over); end
        build_exp(0, 8'd200, 8'd62, 4'd1);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL hit_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
        run_frame(0, 0);
        tests++; if (cap_total != 13) begin failed++; $display("FAIL frozen_count: got %0d expected 13", cap_total); end
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL frozen_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
        run_frame(1, 0);
        tests++; if (game_over !== 1'b0) begin failed++; $display("FAIL restart_flag: got %b expected 0", game_over); end
        build_exp(0, 8'd200, 8'd250, 4'd0);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL restart_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
        run_frame(0, 0);
        tests++; if (cap_data[6] !== 8'd246) begin failed++; $display("FAIL restart_run_cac: got %0d expected 246", cap_data[6]); end
        tests++; if (cap_data[1] !== 8'd200) begin failed++; $display("FAIL restart_no_jump: got %0d expected 200", cap_data[1]); end
    endtask

    task automatic test_score_wrap;
        for (int r = 2; r <= 630; r++) begin
            run_frame(r % 63 == 40, 0);
            if (r == 567) begin
                tests++; if (cap_data[10] !== 8'd9) begin failed++; $display("FAIL score9: got %0d expected 9", cap_data[10]); end
            end
            if (r == 630) begin
                tests++; if (cap_data[10] !== 8'd0) begin failed++; $display("FAIL score_wrap: got %0d expected 0", cap_data[10]); end
                tests++; if (cap_data[6] !== 8'd250) begin failed++; $display("FAIL score_wrap_cac: got %0d expected 250", cap_data[6]); end
            end
        end
        tests++; if (game_over !== 1'b0) begin failed++; $display("FAIL dodge_run: got %b expected 0", game_over); end
    endtask

    task automatic test_stall;
        stall_en = 1;
        run_frame(0, 0);
        stall_en = 0;
        build_exp(0, 8'd200, 8'd246, 4'd0);
        tests++; if (cap_total != 13) begin failed++; $display("FAIL stall_count: got %0d expected 13", cap_total); end
        tests++; if (cap_first != 2) begin failed++; $display("FAIL stall_first: got %0d expected 2", cap_first); end
        tests++; if (cap_last != 17) begin failed++; $display("FAIL stall_last: got %0d expected 17", cap_last); end
        tests++; if (a5_cycles != 4) begin failed++; $display("FAIL stall_hold_cycles: got %0d expected 4", a5_cycles); end
        tests++; if (a5_chg) begin failed++; $display("FAIL stall_hold_data: got changing data expected stable"); end
        tests++; if (!order_ok) begin failed++; $display("FAIL stall_order: got out-of-order addresses expected 0..12"); end
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL stall_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
    endtask

    task automatic test_back_to_back;
        tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL pre_overrun: got %b expected 0", overrun); end
        extra_edges = 1;
        run_frame(0, 0);
        extra_edges = 0;
        tests++; if (cap_total != 26) begin failed++; $display("FAIL b2b_count: got %0d expected 26", cap_total); end
        tests++; if (cap_first != 2) begin failed++; $display("FAIL b2b_first: got %0d expected 2", cap_first); end
        tests++; if (cap_last != 29) begin failed++; $display("FAIL b2b_last: got %0d expected 29", cap_last); end
        tests++; if (!order_ok) begin failed++; $display("FAIL b2b_order: got out-of-order addresses expected 0..12 twice"); end
        tests++; if (cap_data[6] !== 8'd242) begin failed++; $display("FAIL b2b_cac1: got %0d expected 242", cap_data[6]); end
        tests++; if (cap_data[19] !== 8'd238) begin failed++; $display("FAIL b2b_cac2: got %0d expected 238", cap_data[19]); end
        tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL overrun: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        vsync_n = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (bus.av_write !== 1'b1) begin failed++; $display("FAIL mid_burst_active: got %b expected 1", bus.av_write); end
        reset_n = 1'b0;
        #1;
        tests++; if (bus.av_write !== 1'b0) begin failed++; $display("FAIL async_write: got %b expected 0", bus.av_write); end
        tests++; if (bus.av_chipselect !== 1'b0) begin failed++; $display("FAIL async_cs: got %b expected 0", bus.av_chipselect); end
        tests++; if (bus.av_address !== 9'd0) begin failed++; $display("FAIL async_addr: got %0d expected 0", bus.av_address); end
        tests++; if (bus.av_writedata !== 32'd0) begin failed++; $display("FAIL async_data: got %0h expected 0", bus.av_writedata); end
        tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL async_overrun: got %b expected 0", overrun); end
        @(negedge clk);
        vsync_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(0, 0);
        build_exp(0, 8'd200, 8'd246, 4'd0);
        tests++; if (cap_total != 13) begin failed++; $display("FAIL post_reset_count: got %0d expected 13", cap_total); end
        tests++; if (cap_first != 2) begin failed++; $display("FAIL post_reset_first: got %0d expected 2", cap_first); end
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (cap_data[k] !== exp13[k]) begin failed++; $display("FAIL post_reset_data idx%0d: got %0d expected %0d", k, cap_data[k], exp13[k]); end
        end
    endtask

    initial begin
        bus.av_waitrequest = 1'b0;
        stall_en = 0;
        extra_edges = 0;
        test_reset;
        test_idle_frame;
        test_duck;
        test_jump;
        test_cactus_wrap;
        test_collision;
        test_score_wrap;
        test_stall;
        test_back_to_back;
        test_reset_mid_burst;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
